branch_target_unit: RTL and testbench
=====================================

# branch_target_unit

Parametrised successor to the CPU's combinational branch-target adder. It computes PC-relative branch targets with sign extension and configurable widths, and adds a direct-mapped branch target buffer (BTB) with 2-bit saturating predictors. It sits between fetch (lookup port) and execute (resolve port). It issues next-PC predictions and flags mispredictions with a redirect address. Addresses are word-granular; the immediate is never shifted.

## Interface
Parameters:
- PC_W, 8, program-counter width in words.
- IMM_W, 16, immediate field width; sign bit is bit IMM_W-1; must be ≥ PC_W.
- DEPTH, 8, BTB entries; power of 2, 2..PC_W-addressable; IDX_W = log2(DEPTH), TAG_W = PC_W-IDX_W.
- CNT_W, 16, statistics counter width (used only with BTU_COUNTERS_EN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all BTB valid bits.
- lu_valid  in  1  lookup request this cycle.
- lu_pc  in  PC_W  address of the fetched instruction.
- pred_valid  out  1  registered; pulses one cycle after lu_valid.
- pred_taken  out  1  registered prediction.
- pred_target  out  PC_W  registered predicted next PC.
- rs_valid  in  1  branch resolved this cycle.
- rs_pc  in  PC_W  address of the resolved branch.
- rs_pc_next  in  PC_W  address of the following instruction.
- rs_imm  in  IMM_W  branch immediate.
- rs_taken  in  1  actual outcome.
- rs_pred_taken, rs_pred_target  in  1, PC_W  prediction carried down the pipeline.
- mispredict  out  1  registered; pulses one cycle after rs_valid.
- redirect_pc  out  PC_W  registered corrected next PC.

## Operation
- Target: T = (rs_pc_next + sext(rs_imm)) mod 2^PC_W. Truncate to PC_W. Wrap-around is legal and silent.
- Index = pc[IDX_W-1:0]; tag = pc[PC_W-1:IDX_W]. Each entry holds valid, tag, target, and ctr[1:0].
- ctr states: SN=00, WN=01, WT=10, ST=11.
- Lookup: hit = valid && tag match. Predict taken iff hit && ctr[1]. Taken target = entry target; otherwise target = lu_pc+1 (mod 2^PC_W).
- Resolve, hit: ctr moves +1 if taken (saturate at ST) and −1 if not taken (saturate at SN). If taken, target is rewritten with T.
- Resolve, miss, taken: allocate or replace the entry at index with valid=1, tag, target=T, ctr=WT.
- Resolve, miss, not taken: no write.
- mispredict = rs_taken≠rs_pred_taken || (rs_taken && rs_pred_target≠T).
- redirect_pc = T if rs_taken, else rs_pc_next. It is only meaningful while mispredict=1, and holds 0 otherwise.
- flush has priority over a same-cycle resolve write. Flush clears valid bits only; mispredict/redirect are still computed for that resolve.

## Timing
- Reset (async assert, sync-safe release): all valid bits 0, all ctr 0. pred_valid, pred_taken, pred_target, mispredict, and redirect_pc are all 0.
- Reset mid-operation discards in-flight lookups and resolves; no pulse is produced.
- Lookup latency is 1 cycle. Pred outputs hold their last value when pred_valid=0.
- Resolve latency is 1 cycle to mispredict/redirect_pc. Both return to 0 in cycles without rs_valid.
- A BTB write from a resolve at edge N is visible to a lookup sampled at edge N+1.
- A same-cycle lookup and resolve on the same index: the lookup sees pre-update contents.
- Back-to-back lookups and resolves at full rate are supported; there is no stall or back-pressure.

## Configuration
- BTU_COUNTERS_EN defined: adds outputs lookup_cnt, hit_cnt, and mispred_cnt, each CNT_W bits.
  - They count lu_valid, lookup hits, and mispredict pulses.
  - They saturate at all-ones and are cleared only by rst_n; flush does not clear them.
- BTU_COUNTERS_EN undefined: these ports and their registers are absent. All other behaviour is identical.

## Test plan
- Reset then lookup lu_pc=0x10 → pred_taken=0, pred_target=0x11. Assert rst_n low while rs_valid=1 → mispredict stays 0 and all outputs read 0.
- Resolve rs_pc=0x10, rs_pc_next=0x11, rs_imm=0xFFFE, taken, rs_pred_taken=0 → next cycle mispredict=1, redirect_pc=0x0F. Then lookup 0x10 → taken, target 0x0F.
- Wrap: rs_pc_next=0xFE, rs_imm=0x0005, taken → redirect_pc=0x03. rs_imm=0x8000 (IMM_W=16) → T=rs_pc_next.
- After allocation at 0x10 (WT), three not-taken resolves → WN, SN, SN. Lookup 0x10 predicts not taken. Taken resolve with rs_pred_taken=0 → mispredict=1.
- Alias: 0x18 shares index 0 with 0x10 → lookup misses. A taken resolve at 0x18 replaces the entry, and lookup 0x10 then misses.
- Same-cycle lookup and resolve on index 0 → lookup returns old entry. flush with taken resolve → mispredict computed, following lookup misses. With BTU_COUNTERS_EN, counters match stimulus totals.

Source files
------------

// File: rtl/branch_target_unit.sv
// branch_target_unit: PC-relative branch target adder with a direct-mapped BTB and 2-bit predictors; define BTU_COUNTERS_EN to add statistics counters
module branch_target_unit #(
   parameter int PC_W  = 8,
   parameter int IMM_W = 16,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             lu_valid,
   input  logic [PC_W-1:0]  lu_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [PC_W-1:0]  pred_target,
   input  logic             rs_valid,
   input  logic [PC_W-1:0]  rs_pc,
   input  logic [PC_W-1:0]  rs_pc_next,
   input  logic [IMM_W-1:0] rs_imm,
   input  logic             rs_taken,
   input  logic             rs_pred_taken,
   input  logic [PC_W-1:0]  rs_pred_target,
   output logic             mispredict,
   output logic [PC_W-1:0]  redirect_pc
`ifdef BTU_COUNTERS_EN
   ,
   output logic [CNT_W-1:0] lookup_cnt,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] mispred_cnt
`endif
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int TAG_W = PC_W - IDX_W;

   logic [DEPTH-1:0] valid;
   logic [TAG_W-1:0] tag [DEPTH];
   logic [PC_W-1:0]  tgt [DEPTH];
   logic [1:0]       ctr [DEPTH];
   logic [IDX_W-1:0] lu_idx, rs_idx;
   logic             lu_hit, lu_take, rs_hit, mp;
   logic [PC_W-1:0]  t, lu_next;

   // BTB read for lookup and resolve, branch target (imm is never narrower than the PC, so its low bits already carry the sign extension)
   always_comb begin
      lu_idx  = lu_pc[IDX_W-1:0];
      rs_idx  = rs_pc[IDX_W-1:0];
      lu_hit  = valid[lu_idx] && tag[lu_idx] == lu_pc[PC_W-1:IDX_W];
      rs_hit  = valid[rs_idx] && tag[rs_idx] == rs_pc[PC_W-1:IDX_W];
      lu_take = lu_hit && ctr[lu_idx][1];
      lu_next = lu_take ? tgt[lu_idx] : lu_pc + PC_W'(1);
      t       = PC_W'(IMM_W'(rs_pc_next) + rs_imm);
      mp      = (rs_taken != rs_pred_taken) || (rs_taken && rs_pred_target != t);
   end

   // BTB update: flush wins over a resolve write; taken misses allocate as weakly taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag[i] <= '0;
            tgt[i] <= '0;
            ctr[i] <= '0;
         end
      end else if (flush) begin
         valid <= '0;
      end else if (rs_valid) begin
         if (rs_hit) begin
            ctr[rs_idx] <= rs_taken ? (ctr[rs_idx] == 2'b11 ? 2'b11 : ctr[rs_idx] + 2'd1)
                                    : (ctr[rs_idx] == 2'b00 ? 2'b00 : ctr[rs_idx] - 2'd1);
            if (rs_taken) tgt[rs_idx] <= t;
         end else if (rs_taken) begin
            valid[rs_idx] <= 1'b1;
            tag[rs_idx]   <= rs_pc[PC_W-1:IDX_W];
            tgt[rs_idx]   <= t;
            ctr[rs_idx]   <= 2'b10;
         end
      end
   end

   // Registered prediction (held while idle) and mispredict/redirect pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_valid  <= 1'b0;
         pred_taken  <= 1'b0;
         pred_target <= '0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
      end else begin
         pred_valid <= lu_valid;
         if (lu_valid) begin
            pred_taken  <= lu_take;
            pred_target <= lu_next;
         end
         mispredict  <= rs_valid && mp;
         redirect_pc <= (rs_valid && mp) ? (rs_taken ? t : rs_pc_next) : '0;
      end
   end

`ifdef BTU_COUNTERS_EN
   // Saturating statistics, untouched by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lookup_cnt  <= '0;
         hit_cnt     <= '0;
         mispred_cnt <= '0;
      end else begin
         if (lu_valid && ~&lookup_cnt) lookup_cnt <= lookup_cnt + CNT_W'(1);
         if (lu_valid && lu_hit && ~&hit_cnt) hit_cnt <= hit_cnt + CNT_W'(1);
         if (rs_valid && mp && ~&mispred_cnt) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_branch_target_unit.sv
// tb_branch_target_unit: directed scoreboard bench for branch_target_unit
module tb_branch_target_unit;
   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic        lu_valid = 1'b0, rs_valid = 1'b0, rs_taken = 1'b0, rs_pred_taken = 1'b0;
   logic [7:0]  lu_pc = '0, rs_pc = '0, rs_pc_next = '0, rs_pred_target = '0;
   logic [15:0] rs_imm = '0;
   logic        pred_valid, pred_taken, mispredict;
   logic [7:0]  pred_target, redirect_pc;
`ifdef BTU_COUNTERS_EN
   logic [15:0] lookup_cnt, hit_cnt, mispred_cnt;
`endif

   typedef struct packed {logic f; logic [7:0] a;} exp_t;
   exp_t pq[$], rq[$];
   int   tests = 0, fails = 0, lk_n = 0, hit_n = 0, mp_n = 0;
   logic rsd;

   branch_target_unit dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .lu_valid(lu_valid), .lu_pc(lu_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
      .rs_valid(rs_valid), .rs_pc(rs_pc), .rs_pc_next(rs_pc_next), .rs_imm(rs_imm),
      .rs_taken(rs_taken), .rs_pred_taken(rs_pred_taken), .rs_pred_target(rs_pred_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BTU_COUNTERS_EN
      , .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic lookup(input logic [7:0] pc, input logic et, input logic [7:0] ea, input logic eh);
      lu_valid = 1'b1;
      lu_pc    = pc;
      pq.push_back('{f: et, a: ea});
      lk_n++;
      if (eh) hit_n++;
   endtask

   task automatic resolve(input logic [7:0] pc, input logic [7:0] nxt, input logic [15:0] imm,
                          input logic tk, input logic ptk, input logic [7:0] ptgt,
                          input logic emp, input logic [7:0] erd);
      rs_valid       = 1'b1;
      rs_pc          = pc;
      rs_pc_next     = nxt;
      rs_imm         = imm;
      rs_taken       = tk;
      rs_pred_taken  = ptk;
      rs_pred_target = ptgt;
      rq.push_back('{f: emp, a: erd});
      if (emp) mp_n++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      lu_valid = 1'b0;
      rs_valid = 1'b0;
      flush    = 1'b0;
   endtask

   // Tracks which cycles should carry a resolve response
   always @(posedge clk or negedge rst_n)
      if (!rst_n) rsd <= 1'b0;
      else rsd <= rs_valid;

   // Monitor: pops the scoreboard whenever the DUT presents a response
   always @(negedge clk) begin
      exp_t e;
      if (pred_valid) begin
         if (pq.size() == 0) check("pred_unexpected", 1, 0);
         else begin
            e = pq.pop_front();
            check("pred_taken", {31'd0, pred_taken}, {31'd0, e.f});
            check("pred_target", {24'd0, pred_target}, {24'd0, e.a});
         end
      end
      if (rsd) begin
         if (rq.size() == 0) check("rs_unexpected", 1, 0);
         else begin
            e = rq.pop_front();
            check("mispredict", {31'd0, mispredict}, {31'd0, e.f});
            check("redirect_pc", {24'd0, redirect_pc}, {24'd0, e.a});
         end
      end else begin
         check("idle_rs_outputs", {23'd0, mispredict, redirect_pc}, 0);
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_pred_valid", {31'd0, pred_valid}, 0);
      check("rst_pred_taken", {31'd0, pred_taken}, 0);
      check("rst_pred_target", {24'd0, pred_target}, 0);
      check("rst_mispredict", {31'd0, mispredict}, 0);
      check("rst_redirect", {24'd0, redirect_pc}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      lookup(8'h10, 0, 8'h11, 0); step();
      // reset while a mispredicting resolve is pending
      @(negedge clk);
      #1;
      rs_valid = 1'b1; rs_pc = 8'h10; rs_pc_next = 8'h11; rs_imm = 16'hFFFE;
      rs_taken = 1'b1; rs_pred_taken = 1'b0; rs_pred_target = 8'h11;
      rst_n = 1'b0;
      #1;
      check("midrst_pred_valid", {31'd0, pred_valid}, 0);
      check("midrst_pred_target", {24'd0, pred_target}, 0);
      @(posedge clk);
      #1;
      check("midrst_mispredict", {31'd0, mispredict}, 0);
      check("midrst_redirect", {24'd0, redirect_pc}, 0);
      rs_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      lk_n = 0; hit_n = 0; mp_n = 0;
      // allocation, lookup of the new entry, wrap-around targets
      resolve(8'h10, 8'h11, 16'hFFFE, 1, 0, 8'h11, 1, 8'h0F); step();
      lookup(8'h10, 1, 8'h0F, 1); step();
      resolve(8'h21, 8'hFE, 16'h0005, 1, 1, 8'h00, 1, 8'h03); step();
      resolve(8'h22, 8'h40, 16'h8000, 1, 1, 8'h40, 0, 8'h00); step();
      lookup(8'h22, 1, 8'h40, 1); step();
      // counter walk WT->WN->SN->SN, back up to ST, then down
      repeat (3) begin resolve(8'h10, 8'h11, 16'hFFFE, 0, 0, 8'h00, 0, 8'h00); step(); end
      lookup(8'h10, 0, 8'h11, 1); step();
      resolve(8'h10, 8'h11, 16'hFFFE, 1, 0, 8'h11, 1, 8'h0F); step();
      lookup(8'h10, 0, 8'h11, 1); step();
      resolve(8'h10, 8'h11, 16'hFFFE, 1, 1, 8'h0F, 0, 8'h00); step();
      lookup(8'h10, 1, 8'h0F, 1); step();
      repeat (2) begin resolve(8'h10, 8'h11, 16'hFFFE, 1, 1, 8'h0F, 0, 8'h00); step(); end
      lookup(8'h10, 1, 8'h0F, 1); step();
      resolve(8'h10, 8'h11, 16'hFFFE, 0, 1, 8'h0F, 1, 8'h11); step();
      lookup(8'h10, 1, 8'h0F, 1); step();
      resolve(8'h10, 8'h11, 16'hFFFE, 0, 0, 8'h00, 0, 8'h00); step();
      lookup(8'h10, 0, 8'h11, 1); step();
      // aliasing on index 0
      lookup(8'h18, 0, 8'h19, 0); step();
      resolve(8'h18, 8'h19, 16'h0010, 1, 0, 8'h19, 1, 8'h29); step();
      lookup(8'h10, 0, 8'h11, 0); step();
      lookup(8'h18, 1, 8'h29, 1); step();
      // same-cycle lookup and resolve: lookup sees pre-update WT
      lookup(8'h18, 1, 8'h29, 1);
      resolve(8'h18, 8'h19, 16'h0010, 0, 1, 8'h29, 1, 8'h19); step();
      lookup(8'h18, 0, 8'h19, 1); step();
      // flush beats a taken resolve; all entries invalidated
      flush = 1'b1;
      resolve(8'h20, 8'h21, 16'h0002, 1, 0, 8'h21, 1, 8'h23); step();
      lookup(8'h20, 0, 8'h21, 0); step();
      lookup(8'h21, 0, 8'h22, 0); step();
      lookup(8'h22, 0, 8'h23, 0); step();
      lookup(8'hFF, 0, 8'h00, 0); step();
      repeat (3) step();
      check("pred_queue_drained", pq.size(), 0);
      check("rs_queue_drained", rq.size(), 0);
`ifdef BTU_COUNTERS_EN
      check("lookup_cnt", {16'd0, lookup_cnt}, lk_n);
      check("hit_cnt", {16'd0, hit_cnt}, hit_n);
      check("mispred_cnt", {16'd0, mispred_cnt}, mp_n);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
